// File: rtl/pc_stack_if.sv
// Bus bundle for the program-counter / return-stack block.
// WIDTH and DEPTH must match the parameters of the pc_stack attached to it.
interface pc_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             clear;
  logic             load;
  logic             branch;
  logic             incr;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] top;
  logic [SPW-1:0]   sp;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, load, branch, incr, call, ret, in, offset,
    input  out, top, sp, empty, full, overflow, underflow
  );

  modport slave (
    input  clear, load, branch, incr, call, ret, in, offset,
    output out, top, sp, empty, full, overflow, underflow
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a LIFO return stack: one operation per edge,
// priority clear > ret > call > load > branch > incr > hold.
module pc_stack #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic      clk,
  input logic      reset_n,
  pc_stack_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] pc;
  logic [SPW-1:0]   sp_count;
  logic             ovf_flag;
  logic             unf_flag;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic             is_empty;
  logic             is_full;
  logic [SPW-1:0]   sp_dec;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] top_val;
  logic             push_en;

  assign is_empty = (sp_count == '0);
  assign is_full  = (sp_count == SPW'(DEPTH));
  assign sp_dec   = sp_count - SPW'(1);
  // Both indices are in range whenever they are actually used (push when not full, read when not empty).
  assign wr_idx   = sp_count[AW-1:0];
  assign rd_idx   = sp_dec[AW-1:0];
  assign top_val  = is_empty ? RESET_VEC : stack_mem[rd_idx];
  assign push_en  = !bus.clear && !bus.ret && bus.call && !is_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_VEC;
      sp_count <= '0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else if (bus.clear) begin
      pc       <= RESET_VEC;
      sp_count <= '0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else if (bus.ret) begin
      if (!is_empty) begin
        pc       <= top_val;
        sp_count <= sp_dec;
      end else begin
        unf_flag <= 1'b1;
      end
    end else if (bus.call) begin
      pc <= bus.in;
      if (!is_full) begin
        sp_count <= sp_count + SPW'(1);
      end else begin
        ovf_flag <= 1'b1;
      end
    end else if (bus.load) begin
      pc <= bus.in;
    end else if (bus.branch) begin
      pc <= pc + bus.offset;
    end else if (bus.incr) begin
      pc <= pc + WIDTH'(1);
    end
  end

  // Storage is not reset: entries at or above sp are never observable.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[wr_idx] <= pc + WIDTH'(1);
    end
  end

  assign bus.out       = pc;
  assign bus.top       = top_val;
  assign bus.sp        = sp_count;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_flag;
  assign bus.underflow = unf_flag;
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: a reference model pushes expected state
// into a scoreboard as each operation is driven; it is popped after the edge.
module tb_pc_stack;
  localparam int               WIDTH = 16;
  localparam int               DEPTH = 8;
  localparam logic [WIDTH-1:0] RV    = 16'h0000;

  typedef struct {
    string       tag;
    logic [15:0] out;
    logic [3:0]  sp;
    logic [15:0] top;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  logic [15:0] m_pc;
  logic [3:0]  m_sp;
  logic        m_ovf;
  logic        m_unf;
  logic [15:0] m_stk [DEPTH];

  pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RV;
    m_sp  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.clear = 0; bus.ret = 0; bus.call = 0; bus.load = 0;
    bus.branch = 0; bus.incr = 0; bus.in = '0; bus.offset = '0;
  endtask

  task automatic compare_state(input exp_t e);
    check_eq({e.tag, ".out"},   32'(bus.out),       32'(e.out));
    check_eq({e.tag, ".sp"},    32'(bus.sp),        32'(e.sp));
    check_eq({e.tag, ".top"},   32'(bus.top),       32'(e.top));
    check_eq({e.tag, ".empty"}, 32'(bus.empty),     32'(e.empty));
    check_eq({e.tag, ".full"},  32'(bus.full),      32'(e.full));
    check_eq({e.tag, ".ovf"},   32'(bus.overflow),  32'(e.ovf));
    check_eq({e.tag, ".unf"},   32'(bus.underflow), 32'(e.unf));
  endtask

  function automatic exp_t model_snapshot(input string tag);
    exp_t e;
    e.tag   = tag;
    e.out   = m_pc;
    e.sp    = m_sp;
    e.top   = (m_sp == 0) ? RV : m_stk[m_sp - 1];
    e.empty = (m_sp == 0);
    e.full  = (m_sp == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  // ops bits: {clear, ret, call, load, branch, incr}
  task automatic do_op(input string tag, input logic [5:0] ops,
                       input logic [15:0] v_in, input logic [15:0] v_off);
    exp_t e;
    @(negedge clk);
    {bus.clear, bus.ret, bus.call, bus.load, bus.branch, bus.incr} = ops;
    bus.in     = v_in;
    bus.offset = v_off;
    if (ops[5]) begin
      model_reset();
    end else if (ops[4]) begin
      if (m_sp != 0) begin
        m_pc = m_stk[m_sp - 1];
        m_sp = m_sp - 1;
      end else begin
        m_unf = 1'b1;
      end
    end else if (ops[3]) begin
      if (m_sp < DEPTH) begin
        m_stk[m_sp] = m_pc + 16'd1;
        m_sp = m_sp + 1;
      end else begin
        m_ovf = 1'b1;
      end
      m_pc = v_in;
    end else if (ops[2]) begin
      m_pc = v_in;
    end else if (ops[1]) begin
      m_pc = m_pc + v_off;
    end else if (ops[0]) begin
      m_pc = m_pc + 16'd1;
    end
    sb_q.push_back(model_snapshot(tag));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      compare_state(sb_q.pop_front());
    end
  endtask

  localparam logic [5:0] OP_CLEAR  = 6'b100000;
  localparam logic [5:0] OP_RET    = 6'b010000;
  localparam logic [5:0] OP_CALL   = 6'b001000;
  localparam logic [5:0] OP_LOAD   = 6'b000100;
  localparam logic [5:0] OP_BRANCH = 6'b000010;
  localparam logic [5:0] OP_INCR   = 6'b000001;
  localparam logic [5:0] OP_HOLD   = 6'b000000;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_state(model_snapshot("reset"));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) do_op("incr", OP_INCR, '0, '0);
    do_op("load_ffff", OP_LOAD, 16'hFFFF, '0);
    do_op("incr_wrap", OP_INCR, '0, '0);

    do_op("load_10", OP_LOAD, 16'h0010, '0);
    do_op("call_100", OP_CALL, 16'h0100, '0);
    do_op("ret_11", OP_RET, '0, '0);

    do_op("load_20", OP_LOAD, 16'h0020, '0);
    do_op("branch_neg", OP_BRANCH, '0, 16'hFFF0);
    do_op("branch_pos", OP_BRANCH, '0, 16'h0005);
    do_op("hold", OP_HOLD, 16'h1234, 16'h0003);

    do_op("ret_empty", OP_RET, '0, '0);
    do_op("unf_sticky", OP_INCR, '0, '0);
    do_op("clear1", OP_CLEAR, '0, '0);

    for (int i = 0; i < DEPTH; i++) do_op("fill", OP_CALL, 16'h1000 + 16'(i * 16), '0);
    do_op("call_over", OP_CALL, 16'h0AAA, '0);
    do_op("ovf_sticky", OP_CALL, 16'h0BBB, '0);
    for (int i = 0; i < DEPTH; i++) do_op("unwind", OP_RET, '0, '0);
    do_op("ret_after", OP_RET, '0, '0);

    do_op("call_pre", OP_CALL, 16'h0200, '0);
    do_op("prio_ret", OP_RET | OP_CALL | OP_LOAD, 16'h0777, '0);
    do_op("call_pre2", OP_CALL, 16'h0300, '0);
    do_op("prio_clear", OP_CLEAR | OP_RET, '0, '0);
    do_op("prio_call", OP_CALL | OP_LOAD | OP_INCR, 16'h0440, '0);
    do_op("prio_load", OP_LOAD | OP_BRANCH | OP_INCR, 16'h0550, 16'h0010);
    do_op("prio_branch", OP_BRANCH | OP_INCR, '0, 16'h0010);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] ops;
      ops = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) != 0) ops[5] = 1'b0;
      do_op("rand", ops, 16'($urandom), 16'($urandom));
    end

    do_op("clear2", OP_CLEAR, '0, '0);
    for (int i = 0; i < 3; i++) do_op("pre_rst", OP_CALL, 16'h0500 + 16'(i), '0);
    @(negedge clk);
    bus.call = 1'b1;
    bus.in   = 16'h0600;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("async.out", 32'(bus.out), 32'(RV));
    check_eq("async.sp", 32'(bus.sp), 32'd0);
    check_eq("async.empty", 32'(bus.empty), 32'd1);
    @(posedge clk);
    #1;
    compare_state(model_snapshot("in_reset"));
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    do_op("post_rst", OP_INCR, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
